// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider.
// Holds the controller state encoding and the default datapath sizes.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/seq_divider_sub_stage.sv
// Ripple subtractor built from the ALU full-adder cell: a_i - b_i computed as
// a_i + ~b_i + 1.
// Ports:
//   a_i      minuend
//   b_i      subtrahend
//   diff_o   a_i - b_i (modulo 2^W)
//   borrow_o 1 when b_i > a_i (unsigned), i.e. inverted adder carry-out
module seq_divider_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module seq_divider_sub_stage #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);
    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_cell
        seq_divider_full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign borrow_o = ~carry[W];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider (one quotient bit per clock).
// Ports:
//   clock, reset_n                  system clock, async active-low reset
//   ctrl_div                        start strobe (restarts any operation in flight)
//   data_operandA / data_operandB   dividend / divisor, sampled with ctrl_div
//   data_result / data_remainder    signed quotient / remainder (held)
//   data_exception                  divide-by-zero flag (held until next start)
//   data_resultRDY                  one-cycle completion pulse
//
// state   | meaning
// --------+--------------------------------------------
// IDLE    | waiting for a start strobe
// RUN     | iterating, one quotient bit per cycle
// FIX     | applying signs and loading the outputs
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] neg_a, neg_b, neg_quo, neg_rem;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [3:0]       unused_borrow;

    // Partial remainder with the next dividend bit shifted in.
    logic [WIDTH:0]   shifted;
    assign shifted = {rem_q, quo_q[WIDTH-1]};

    seq_divider_sub_stage #(.W(WIDTH+1)) u_trial (
        .a_i      (shifted),
        .b_i      ({1'b0, div_q}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    // Negations as 0 - x on the same cell chain.
    seq_divider_sub_stage #(.W(WIDTH)) u_neg_a (
        .a_i ('0), .b_i (data_operandA), .diff_o (neg_a), .borrow_o (unused_borrow[0])
    );
    seq_divider_sub_stage #(.W(WIDTH)) u_neg_b (
        .a_i ('0), .b_i (data_operandB), .diff_o (neg_b), .borrow_o (unused_borrow[1])
    );
    seq_divider_sub_stage #(.W(WIDTH)) u_neg_q (
        .a_i ('0), .b_i (quo_q), .diff_o (neg_quo), .borrow_o (unused_borrow[2])
    );
    seq_divider_sub_stage #(.W(WIDTH)) u_neg_r (
        .a_i ('0), .b_i (rem_q), .diff_o (neg_rem), .borrow_o (unused_borrow[3])
    );

    // |-2^(WIDTH-1)| wraps to itself, which is the correct unsigned magnitude.
    assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            res_q    <= '0;
            remo_q   <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            res_q    <= res_d;
            remo_q   <= remo_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        res_d    = res_q;
        remo_d   = remo_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        dz_d     = 1'b0;

        if (ctrl_div) begin
            cnt_d = '0;
            if (data_operandB == '0) begin
                // Outputs update now; the completion pulse follows one edge later.
                state_d = ST_IDLE;
                res_d   = '0;
                remo_d  = '0;
                exc_d   = 1'b1;
                dz_d    = 1'b1;
            end else begin
                state_d  = ST_RUN;
                quo_d    = abs_a;
                div_d    = abs_b;
                rem_d    = '0;
                sign_q_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r_d = data_operandA[WIDTH-1];
                exc_d    = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    rdy_d = dz_q;
                end
                ST_RUN: begin
                    rem_d = trial_borrow ? shifted[WIDTH-1:0] : trial_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial_borrow};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    res_d   = sign_q_q ? neg_quo : quo_q;
                    remo_d  = sign_r_q ? neg_rem : rem_q;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign data_result    = res_q;
    assign data_remainder = remo_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    seq_divider dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic at 64 bits, truncated back to 32.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'd0; r = 32'd0; e = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            e  = 1'b0;
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_div      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Negedge n after the start edge lies between E0+n-1 and E0+n.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ee;
        int          lat, pulses, exp_lat;
        model(a, b, eq, er, ee);
        exp_lat = (b == 32'd0) ? 2 : 34;
        start(a, b);
        chk({tag, ".exc_at_start"}, {31'd0, data_exception}, {31'd0, ee});
        if (b == 32'd0) begin
            chk({tag, ".dz_res_at_start"}, data_result, 32'd0);
            chk({tag, ".dz_rem_at_start"}, data_remainder, 32'd0);
        end
        lat = 0; pulses = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".pulses"}, pulses, 32'd1);
        chk({tag, ".result"}, data_result, eq);
        chk({tag, ".remainder"}, data_remainder, er);
        chk({tag, ".exception"}, {31'd0, data_exception}, {31'd0, ee});
    endtask

    initial begin
        int lat, pulses, mode;
        logic [31:0] ra, rb;

        reset_n = 1'b0; ctrl_div = 1'b0; data_operandA = '0; data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("reset.result", data_result, 32'd0);
        chk("reset.remainder", data_remainder, 32'd0);
        chk("reset.exception", {31'd0, data_exception}, 32'd0);
        chk("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op("pos_pos", 32'd7, 32'd2);
        run_op("neg_pos", 32'hFFFFFFF9, 32'd2);
        run_op("pos_neg", 32'd7, 32'hFFFFFFFE);
        run_op("div_zero", 32'd5, 32'd0);
        run_op("after_dz", 32'd100, 32'd9);
        run_op("min_by_m1", 32'h80000000, 32'hFFFFFFFF);
        run_op("min_by_1", 32'h80000000, 32'd1);
        run_op("max_by_min", 32'h7FFFFFFF, 32'h80000000);

        // Restart mid-run: only the second operation completes.
        start(32'd100, 32'd7);
        lat = 0; pulses = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clock);
            if (n == 10) begin
                ctrl_div = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
            end else if (n == 11) begin
                ctrl_div = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
            end
            if (data_resultRDY === 1'b1) begin
                pulses++;
                if (lat == 0) lat = n;
            end
        end
        chk("restart.pulses", pulses, 32'd1);
        chk("restart.latency", lat, 32'd44);
        chk("restart.result", data_result, 32'd3);
        chk("restart.remainder", data_remainder, 32'd0);

        // Async reset while running discards the operation.
        start(32'd100, 32'd7);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst.result", data_result, 32'd0);
        chk("arst.remainder", data_remainder, 32'd0);
        chk("arst.exception", {31'd0, data_exception}, 32'd0);
        chk("arst.rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
        chk("arst.no_rdy", pulses, 32'd0);
        run_op("post_rst", 32'd8, 32'd4);

        for (int i = 0; i < 20; i++) begin
            mode = $urandom_range(0, 3);
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = $urandom_range(0, 1000);
            case (mode)
                0: rb = $urandom;
                1: begin
                    rb = $urandom_range(1, 20);
                    if ($urandom_range(0, 1) == 1) rb = -rb;
                end
                2: rb = {16'd0, 16'($urandom)} | 32'd1;
                default: rb = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'hFFFFFFFF;
            endcase
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed integer divider for the processor's multdiv path.
- Computes quotient and remainder by restoring division, one trial subtraction per clock.
- Built from the same ripple adder cells as the ALU, wired as subtractors (adder inverted, B complemented, carry-in = 1).
- Sits beside the ALU in the execute stage; the pipeline stalls on ctrl_div until data_resultRDY pulses.

Parameters:
- WIDTH, 32, operand and result width in bits (two's complement).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_div  input  1  start strobe, sampled on rising edge; one-cycle pulse expected.
- data_operandA  input  WIDTH  dividend, sampled only on the edge where ctrl_div=1.
- data_operandB  input  WIDTH  divisor, sampled only on the edge where ctrl_div=1.
- data_result  output  WIDTH  signed quotient.
- data_remainder  output  WIDTH  signed remainder.
- data_exception  output  1  divide-by-zero flag; valid while data_resultRDY=1 and held afterwards.
- data_resultRDY  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, counter=0; data_result, data_remainder, data_exception and data_resultRDY all 0. An operation in flight is discarded and no RDY is issued for it.
- States:
  - IDLE: waiting for a start strobe.
  - RUN: iterating, one quotient bit per cycle.
  - FIX: applying signs and loading the outputs.
- Transitions:
  - Any state, ctrl_div=1 with B!=0: go to RUN.
  - Any state, ctrl_div=1 with B==0: go to IDLE and raise the divide-by-zero pulse.
  - RUN: after WIDTH iterations, go to FIX.
  - FIX: go to IDLE.
- Start edge E0 (ctrl_div=1):
  - Latch |A| and |B|.
  - Latch sign_q = A[MSB]^B[MSB] and sign_r = A[MSB].
  - Clear the partial remainder and counter; deassert data_exception.
- RUN, each edge:
  - Shift {rem, quo} left by one; the MSB of the dividend shifts into rem.
  - Trial-subtract rem - |B| at WIDTH+1 bits.
  - If there is no borrow, keep the difference and set the quotient LSB to 1; otherwise restore rem and set the LSB to 0.
  - Increment the counter.
- FIX edge:
  - Result = sign_q ? -quo : quo.
  - Remainder = sign_r ? -rem : rem.
  - Register both outputs and assert data_resultRDY.
- Latency:
  - Normal operation: data_resultRDY is high for exactly the one cycle following edge E0+WIDTH+1 (E0+33 for WIDTH=32).
  - Divide by zero: detected at E0. On that edge data_result=0, data_remainder=0 and data_exception=1, and data_resultRDY is high for the one cycle following E0+1.
- Rounding: quotient truncates toward zero. Remainder takes the sign of the dividend, so A = q*B + r always holds (mod 2^WIDTH).
- Overflow: A=-2^(WIDTH-1), B=-1 gives result 0x80000000 (wraps), remainder 0, data_exception=0.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held unsigned in WIDTH bits; this is correct without extension.
- Restart: ctrl_div=1 during RUN or FIX aborts the current operation, re-latches the operands and restarts the counter. Only the new operation produces an RDY. ctrl_div on the same edge as FIX completion also wins: there is no RDY for the old operation.
- Outputs hold their last value until the next FIX or divide-by-zero update. They are not cleared by a new start, except that data_exception clears at E0.
- Operands may change freely after E0; they are not re-sampled.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIX=2'd2.
  - Default WIDTH=32 and CNT_W=6.
- Sub-module sub_stage is natural: a combinational WIDTH+1-bit ripple subtractor built from full_adder cells, with B inverted and c_in=1.
  - Outputs: difference, and borrow = ~carry_out.
  - One instance is used per cycle, in the trial subtract.
  - The sign-fix negations reuse the same cell chain pattern (0 - x).

Test Plan:
- A=7, B=2 strobe at E0 -> RDY one cycle after E0+33, result=3, remainder=1, exception=0.
- A=-7 (0xFFFFFFF9), B=2 -> result=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); A=7, B=-2 -> result -3, remainder 1.
- A=5, B=0 -> RDY one cycle after E0+1, exception=1, result=0, remainder=0; the next valid divide clears exception at its start edge.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=0; A=0x80000000, B=1 -> result=0x80000000.
- A=100, B=7 at E0, then A=9, B=3 strobed at E0+10 -> exactly one RDY, one cycle after E0+43, result=3, remainder=0; no pulse near E0+33.
- A=100, B=7 at E0, reset_n=0 asynchronously between E0+5 and E0+6, then released -> all outputs read 0 immediately; no RDY ever; a subsequent 8/4 gives result 2 at the normal latency.
